if1_fetch_ctrl: RTL and testbench
=================================

// Module: if1_fetch_ctrl
// PURPOSE
//  Fetch-side writer for the instruction FIFO.
//  - Generates the fetch PC and drives the icache request handshake.
//  - Unpacks each 64-bit icache line into one or two entries on icache_bus_0/1 + valid_i_0/1.
//  - Obeys fifo_allowin; redirects on ds_flush; raises AdEL on a misaligned PC.
//  - Sits between the PC/icache front end and the instruction FIFO feeding decode.
// PARAMETERS
//  RESET_PC   32'hbfc00000   fetch PC loaded on reset
//  EXC_ADEL   5'h04          excode written for a misaligned fetch PC
// PORTS
//  clk            in   1    clock
//  reset          in   1    asynchronous, active-high reset
//  ds_flush       in   1    redirect request from hazard unit
//  flush_pc       in   32   new fetch PC, valid with ds_flush
//  fifo_allowin   in   1    FIFO has >=4 free slots
//  inst_req       out  1    icache request
//  inst_addr      out  32   icache address = {pc[31:3],3'b0}
//  inst_addr_ok   in   1    request accepted this cycle
//  inst_data_ok   in   1    read data returned this cycle
//  inst_rdata     in   64   [31:0] word at addr, [63:32] word at addr+4
//  valid_i_0      out  1    write slot 0 to FIFO this cycle
//  valid_i_1      out  1    write slot 1 to FIFO this cycle (only with valid_i_0)
//  icache_bus_0   out  `CACHE_TO_FIFO_WD   {ex,excode[4:0],pd_pc,inst,pc} = 102 bits
//  icache_bus_1   out  `CACHE_TO_FIFO_WD   same format, second instruction
//  fetch_pc       out  32   current fetch PC (debug / IF1 consumers)
// BEHAVIOUR
//  Reset (async): state=RUN, pc=RESET_PC, outstanding=0.
//   All outputs 0 except fetch_pc=RESET_PC and inst_addr={RESET_PC[31:3],3'b0}.
//  FSM states: RUN, WAIT, DISCARD, EXC, HALT.
//  RUN:
//   - pc[1:0]!=0 -> EXC; no request issued.
//   - Otherwise inst_req = fifo_allowin & !ds_flush.
//   - inst_req & inst_addr_ok -> WAIT; latch pc into req_pc.
//   - A request may be withdrawn before addr_ok; addr is then free to change.
//  WAIT:
//   - inst_req=0. At most one outstanding request.
//   - On inst_data_ok & !ds_flush:
//     - valid_i_0=1, in the same cycle (combinational from data_ok).
//     - req_pc[2]==0: valid_i_1=1; slot0 inst=rdata[31:0], slot1 inst=rdata[63:32];
//       pc <= req_pc+8.
//     - req_pc[2]==1: slot0 only, inst=rdata[63:32]; pc <= req_pc+4.
//     - Next state RUN.
//   - Data is pushed even if fifo_allowin dropped after addr_ok; the FIFO's 4-slot margin covers it.
//  Entry fields:
//   - pc = word address; pd_pc = pc+4 (no prediction).
//   - ex=0, excode=0.
//   - Unused slot bus = all zeros.
//  Flush (highest priority, any state):
//   - pc <= flush_pc; valid_i_0/1 forced 0 in the flush cycle.
//   - WAIT without data_ok that cycle -> DISCARD.
//   - RUN with inst_req & addr_ok in the flush cycle: the request counts as outstanding -> DISCARD.
//   - All other cases -> RUN.
//  DISCARD:
//   - inst_req=0. The next inst_data_ok is dropped (no FIFO write) -> RUN.
//   - A flush in DISCARD updates pc and stays in DISCARD.
//   - A flush coincident with data_ok updates pc, drops the data -> RUN.
//  EXC:
//   - When fifo_allowin: one cycle valid_i_0=1, slot0 = {1,EXC_ADEL,pc+4,32'h0,pc} -> HALT.
//  HALT: inst_req=0, no writes until ds_flush.
//  Arithmetic: 32-bit PC adds wrap modulo 2^32 (32'hfffffff8+8 -> 0).
// TESTING
//  T1 Release reset; addr_ok in cycle 1; data_ok in cycle 2, rdata=64'h22222222_11111111:
//     -> valid_i_0/1=1;
//     -> slot0 {pc=bfc00000, inst=11111111, pd=bfc00004};
//     -> slot1 {pc=bfc00004, inst=22222222, pd=bfc00008};
//     -> next inst_addr=bfc00008.
//  T2 Flush to 80000004, then data_ok with rdata=64'hAAAA0000_BBBB0000:
//     -> inst_addr=80000000; only valid_i_0, inst=AAAA0000, pc=80000004;
//     -> next inst_addr=80000008.
//  T3 ds_flush (flush_pc=80001000) while in WAIT, data_ok 3 cycles later:
//     -> no FIFO write; next inst_req has addr 80001000.
//  T4 fifo_allowin=0 in RUN for 10 cycles -> inst_req stays 0.
//     fifo_allowin drops in WAIT -> returning data still written.
//  T5 Flush to 80000002:
//     -> no inst_req; one entry {ex=1, excode=04, pc=80000002, inst=0};
//     -> silent until next flush; flush to 80000000 resumes fetch.
//  T6 Async reset asserted mid-WAIT, between clock edges:
//     -> valid_i_0/1 and inst_req go 0 immediately; fetch_pc=bfc00000;
//     -> late data_ok after release is ignored.

Source files
------------

// File: rtl/if1_fetch_ctrl.sv
// IF1 fetch controller: issues icache requests for the fetch PC and unpacks each
// returned 64-bit line into one or two instruction-FIFO entries.
`ifndef CACHE_TO_FIFO_WD
`define CACHE_TO_FIFO_WD 102
`endif

module if1_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [4:0]  EXC_ADEL = 5'h04
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ds_flush,
  input  logic [31:0]                  flush_pc,
  input  logic                         fifo_allowin,
  output logic                         inst_req,
  output logic [31:0]                  inst_addr,
  input  logic                         inst_addr_ok,
  input  logic                         inst_data_ok,
  input  logic [63:0]                  inst_rdata,
  output logic                         valid_i_0,
  output logic                         valid_i_1,
  output logic [`CACHE_TO_FIFO_WD-1:0] icache_bus_0,
  output logic [`CACHE_TO_FIFO_WD-1:0] icache_bus_1,
  output logic [31:0]                  fetch_pc
);

  typedef enum logic [2:0] {RUN, WAIT, DISCARD, EXC, HALT} state_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] pd_pc;
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc;
  entry_t      slot0, slot1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (inst_req && inst_addr_ok)
        req_pc <= pc;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_req  = 1'b0;
    valid_i_0 = 1'b0;
    valid_i_1 = 1'b0;
    slot0     = '0;
    slot1     = '0;

    case (state)
      RUN: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = EXC;
        end else begin
          inst_req = fifo_allowin && !ds_flush;
          if (inst_req && inst_addr_ok)
            state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          valid_i_0   = 1'b1;
          slot0.pc    = req_pc;
          slot0.pd_pc = req_pc + 32'd4;
          if (!req_pc[2]) begin
            valid_i_1   = 1'b1;
            slot0.inst  = inst_rdata[31:0];
            slot1.pc    = req_pc + 32'd4;
            slot1.pd_pc = req_pc + 32'd8;
            slot1.inst  = inst_rdata[63:32];
            pc_nxt      = req_pc + 32'd8;
          end else begin
            slot0.inst  = inst_rdata[63:32];
            pc_nxt      = req_pc + 32'd4;
          end
          state_nxt = RUN;
        end
      end
      DISCARD: begin
        if (inst_data_ok)
          state_nxt = RUN;
      end
      EXC: begin
        if (fifo_allowin) begin
          valid_i_0    = 1'b1;
          slot0.ex     = 1'b1;
          slot0.excode = EXC_ADEL;
          slot0.pd_pc  = pc + 32'd4;
          slot0.pc     = pc;
          state_nxt    = HALT;
        end
      end
      HALT: ;
      default: state_nxt = RUN;
    endcase

    // A redirect overrides everything; an accepted-but-unreturned request must be drained.
    if (ds_flush) begin
      pc_nxt    = flush_pc;
      valid_i_0 = 1'b0;
      valid_i_1 = 1'b0;
      slot0     = '0;
      slot1     = '0;
      case (state)
        WAIT, DISCARD: state_nxt = inst_data_ok ? RUN : DISCARD;
        RUN:           state_nxt = (inst_req && inst_addr_ok) ? DISCARD : RUN;
        default:       state_nxt = RUN;
      endcase
    end

    // Outputs are held quiet for the whole time reset is asserted.
    if (reset) begin
      inst_req  = 1'b0;
      valid_i_0 = 1'b0;
      valid_i_1 = 1'b0;
      slot0     = '0;
      slot1     = '0;
    end
  end

  assign inst_addr    = {pc[31:3], 3'b000};
  assign fetch_pc     = pc;
  assign icache_bus_0 = slot0;
  assign icache_bus_1 = slot1;

endmodule

// File: tb/tb_if1_fetch_ctrl.sv
// Scoreboard bench for if1_fetch_ctrl: a behavioural icache/FIFO model predicts
// the FIFO entries; a negedge monitor pops and compares whatever the DUT writes.
module tb_if1_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_flush;
  logic [31:0]  flush_pc;
  logic         fifo_allowin;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_addr_ok;
  logic         inst_data_ok;
  logic [63:0]  inst_rdata;
  logic         valid_i_0;
  logic         valid_i_1;
  logic [101:0] icache_bus_0;
  logic [101:0] icache_bus_1;
  logic [31:0]  fetch_pc;

  int checks = 0;
  int errors = 0;

  logic [101:0] exp_q0[$];
  logic [101:0] exp_q1[$];
  logic [101:0] mon_e;
  logic [31:0]  model_pc;

  if1_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ds_flush     (ds_flush),
    .flush_pc     (flush_pc),
    .fifo_allowin (fifo_allowin),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .valid_i_0    (valid_i_0),
    .valid_i_1    (valid_i_1),
    .icache_bus_0 (icache_bus_0),
    .icache_bus_1 (icache_bus_1),
    .fetch_pc     (fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [101:0] mk(input logic ex, input logic [4:0] code,
                                      input logic [31:0] pc, input logic [31:0] inst);
    return {ex, code, pc + 32'd4, inst, pc};
  endfunction

  // Expected FIFO entries for one returned line fetched at model_pc.
  task automatic expect_line(input logic [63:0] rd);
    if (model_pc[2] == 1'b0) begin
      exp_q0.push_back(mk(1'b0, 5'h0, model_pc, rd[31:0]));
      exp_q1.push_back(mk(1'b0, 5'h0, model_pc + 32'd4, rd[63:32]));
      model_pc = model_pc + 32'd8;
    end else begin
      exp_q0.push_back(mk(1'b0, 5'h0, model_pc, rd[63:32]));
      model_pc = model_pc + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid_i_0) begin
        if (exp_q0.size() == 0) check("spurious_slot0", valid_i_0, 0);
        else begin
          mon_e = exp_q0.pop_front();
          check("slot0", icache_bus_0, mon_e);
        end
        if (!valid_i_1) check("slot1_idle_bus", icache_bus_1, 0);
      end
      if (valid_i_1) begin
        check("v1_needs_v0", valid_i_0, 1);
        if (exp_q1.size() == 0) check("spurious_slot1", valid_i_1, 0);
        else begin
          mon_e = exp_q1.pop_front();
          check("slot1", icache_bus_1, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] npc);
    ds_flush = 1'b1;
    flush_pc = npc;
    #1 check("flush_no_req", inst_req, 0);
    step();
    ds_flush = 1'b0;
    model_pc = npc;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!inst_req && n < 20) begin
      step();
      n++;
    end
    check("req_raised", inst_req, 1);
  endtask

  // mode: 0 normal, 1 flush in WAIT, 2 flush with data_ok, 3 flush in WAIT then again in DISCARD
  task automatic fetch(input int a_dly, input int d_dly, input int mode, input logic [63:0] rd,
                       input logic [31:0] fpc, input bit drop);
    fifo_allowin = 1'b1;
    wait_req();
    check("req_addr", inst_addr, {model_pc[31:3], 3'b000});
    repeat (a_dly) begin
      step();
      check("req_held", inst_req, 1);
    end
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    check("wait_no_req", inst_req, 0);
    if (drop) fifo_allowin = 1'b0;
    if (mode == 1 || mode == 3) begin
      ds_flush = 1'b1;
      flush_pc = fpc;
      step();
      ds_flush = 1'b0;
      model_pc = fpc;
    end
    if (mode == 3) begin
      ds_flush = 1'b1;
      flush_pc = fpc + 32'h100;
      step();
      ds_flush = 1'b0;
      model_pc = fpc + 32'h100;
    end
    repeat (d_dly) begin
      check("pending_no_req", inst_req, 0);
      step();
    end
    inst_rdata   = rd;
    inst_data_ok = 1'b1;
    if (mode == 2) begin
      ds_flush = 1'b1;
      flush_pc = fpc;
      model_pc = fpc;
    end else if (mode == 0) begin
      expect_line(rd);
    end
    step();
    inst_data_ok = 1'b0;
    ds_flush     = 1'b0;
    fifo_allowin = 1'b1;
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r = 32'hfffffff8 | (r & 32'h4);
    r[1:0] = 2'b00;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    ds_flush     = 1'b0;
    flush_pc     = '0;
    fifo_allowin = 1'b1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    model_pc     = RESET_PC;

    #2;
    check("rst_req", inst_req, 0);
    check("rst_v0", valid_i_0, 0);
    check("rst_v1", valid_i_1, 0);
    check("rst_fetch_pc", fetch_pc, RESET_PC);
    check("rst_addr", inst_addr, {RESET_PC[31:3], 3'b000});
    check("rst_bus0", icache_bus_0, 0);
    step();
    step();
    reset = 1'b0;

    // T1: first line at reset PC, both slots
    fetch(0, 0, 0, 64'h22222222_11111111, 32'h0, 1'b0);
    check("t1_next_addr", inst_addr, 32'hbfc00008);

    // T2: odd-word redirect yields a single entry from the upper word
    do_flush(32'h80000004);
    fetch(0, 0, 0, 64'hAAAA0000_BBBB0000, 32'h0, 1'b0);
    check("t2_next_addr", inst_addr, 32'h80000008);

    // T3: flush while waiting drops the returned line
    fetch(1, 2, 1, 64'h12345678_9abcdef0, 32'h80001000, 1'b0);
    check("t3_fetch_pc", fetch_pc, 32'h80001000);

    // T4: no request while FIFO is full; data still written after allowin drops in WAIT
    fifo_allowin = 1'b0;
    repeat (10) begin
      step();
      check("t4_no_req", inst_req, 0);
    end
    fetch(2, 3, 0, 64'hdeadbeef_cafef00d, 32'h0, 1'b1);

    // T5: misaligned PC raises a single AdEL entry, then halts until redirected
    fifo_allowin = 1'b1;
    exp_q0.push_back(mk(1'b1, 5'h04, 32'h80000002, 32'h0));
    do_flush(32'h80000002);
    check("t5_misaligned_no_req", inst_req, 0);
    fifo_allowin = 1'b0;
    step();
    check("t5_exc_no_req", inst_req, 0);
    step();
    fifo_allowin = 1'b1;
    step();
    repeat (5) begin
      check("t5_halt_no_req", inst_req, 0);
      step();
    end
    check("t5_exc_drain", exp_q0.size(), 0);
    do_flush(32'h80000000);
    fetch(0, 1, 0, 64'h0badc0de_00c0ffee, 32'h0, 1'b0);

    // T6: asynchronous reset mid-WAIT, then a stale data_ok is ignored
    fifo_allowin = 1'b1;
    wait_req();
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    #1;
    inst_rdata   = 64'h55555555_66666666;
    inst_data_ok = 1'b1;
    #1 check("t6_pre_reset_v0", valid_i_0, 1);
    reset = 1'b1;
    #1;
    check("t6_v0", valid_i_0, 0);
    check("t6_v1", valid_i_1, 0);
    check("t6_req", inst_req, 0);
    check("t6_fetch_pc", fetch_pc, RESET_PC);
    inst_data_ok = 1'b0;
    step();
    step();
    fifo_allowin = 1'b0;
    reset        = 1'b0;
    step();
    inst_data_ok = 1'b1;
    step();
    inst_data_ok = 1'b0;
    step();
    model_pc = RESET_PC;
    check("t6_late_pc", fetch_pc, model_pc);
    fetch(0, 0, 0, 64'h77777777_88888888, 32'h0, 1'b0);

    // Randomized traffic: redirects, handshake latencies, flush timing, allowin drops
    for (int i = 0; i < 150; i++) begin
      int m;
      if ($urandom_range(0, 3) == 0) do_flush(rand_pc());
      m = $urandom_range(0, 5);
      fetch($urandom_range(0, 3), $urandom_range(0, 3), (m > 3) ? 0 : m,
            {$urandom, $urandom}, rand_pc(), 1'($urandom_range(0, 1)));
      check("rand_fetch_pc", fetch_pc, model_pc);
    end

    step();
    check("final_q0", exp_q0.size(), 0);
    check("final_q1", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
